// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the two-port data-memory arbiter: CPU port (a_*),
// loader/debug port (b_*) and the single data-memory port.
interface dmem_arbiter_if;
    // CPU port
    logic        a_req;
    logic        a_we;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic        a_gnt;
    logic        a_rvalid;
    logic        a_err;
    logic [31:0] a_rdata;

    // Loader / debug port
    logic        b_req;
    logic        b_we;
    logic [31:0] b_addr;
    logic [31:0] b_wdata;
    logic        b_gnt;
    logic        b_rvalid;
    logic        b_err;
    logic [31:0] b_rdata;

    // Data memory port (combinational read data returned on DataOut)
    logic        mRD;
    logic        mWR;
    logic [31:0] DataAddr;
    logic [31:0] DataIn;
    logic [31:0] DataOut;

    // Arbiter side
    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_err, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_err, b_rdata,
        output mRD, mWR, DataAddr, DataIn,
        input  DataOut
    );

    // Requesters plus memory model side
    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_err, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_err, b_rdata,
        input  mRD, mWR, DataAddr, DataIn,
        output DataOut
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter. Port A (CPU) wins ties from IDLE; a port that
// was just granted is masked for one cycle, so alternating traffic gets a grant
// every cycle and neither port can starve the other. All outputs are registered.
module dmem_arbiter #(
    parameter int DEPTH = 258
) (
    input  logic          CLK,
    input  logic          Reset,
    dmem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t      state_q, state_d;
    logic        ready_q;          // first posedge after reset only arms the arbiter
    logic        a_gnt_q, b_gnt_q;
    logic        mrd_q, mwr_q;
    logic [31:0] addr_q, din_q;
    logic        acc_we_q, acc_legal_q;   // attributes of the access in its gnt cycle
    logic        a_rvalid_q, a_err_q, b_rvalid_q, b_err_q;
    logic [31:0] a_rdata_q, b_rdata_q;
    logic        a_legal, b_legal;

    // Word-aligned and inside the memory
    function automatic logic addr_legal(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < DEPTH_W);
    endfunction

    assign a_legal = addr_legal(bus.a_addr);
    assign b_legal = addr_legal(bus.b_addr);

    // Next-state: A priority from IDLE, the just-served port is masked
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE: begin
                if (!ready_q)        state_d = IDLE;
                else if (bus.a_req)  state_d = GRANT_A;
                else if (bus.b_req)  state_d = GRANT_B;
                else                 state_d = IDLE;
            end
            GRANT_A: state_d = bus.b_req ? GRANT_B : IDLE;
            GRANT_B: state_d = bus.a_req ? GRANT_A : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, memory strobes and per-port completion registers
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            a_gnt_q     <= 1'b0;
            b_gnt_q     <= 1'b0;
            mrd_q       <= 1'b0;
            mwr_q       <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            acc_we_q    <= 1'b0;
            acc_legal_q <= 1'b0;
            a_rvalid_q  <= 1'b0;
            a_err_q     <= 1'b0;
            b_rvalid_q  <= 1'b0;
            b_err_q     <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= 1'b1;
            a_gnt_q    <= (state_d == GRANT_A);
            b_gnt_q    <= (state_d == GRANT_B);
            mrd_q      <= 1'b0;
            mwr_q      <= 1'b0;
            a_rvalid_q <= 1'b0;
            a_err_q    <= 1'b0;
            b_rvalid_q <= 1'b0;
            b_err_q    <= 1'b0;

            // Launch the access being granted; illegal ones keep strobes low
            if (state_d == GRANT_A) begin
                addr_q      <= {2'b00, bus.a_addr[31:2]};
                din_q       <= bus.a_wdata;
                mrd_q       <= ~bus.a_we & a_legal;
                mwr_q       <= bus.a_we & a_legal;
                acc_we_q    <= bus.a_we;
                acc_legal_q <= a_legal;
            end else if (state_d == GRANT_B) begin
                addr_q      <= {2'b00, bus.b_addr[31:2]};
                din_q       <= bus.b_wdata;
                mrd_q       <= ~bus.b_we & b_legal;
                mwr_q       <= bus.b_we & b_legal;
                acc_we_q    <= bus.b_we;
                acc_legal_q <= b_legal;
            end

            // Complete the access whose gnt cycle ends at this edge
            if (state_q == GRANT_A) begin
                if (!acc_legal_q) begin
                    a_err_q <= 1'b1;
                end else if (!acc_we_q) begin
                    a_rvalid_q <= 1'b1;
                    a_rdata_q  <= bus.DataOut;
                end
            end else if (state_q == GRANT_B) begin
                if (!acc_legal_q) begin
                    b_err_q <= 1'b1;
                end else if (!acc_we_q) begin
                    b_rvalid_q <= 1'b1;
                    b_rdata_q  <= bus.DataOut;
                end
            end
        end
    end

    assign bus.a_gnt    = a_gnt_q;
    assign bus.b_gnt    = b_gnt_q;
    assign bus.mRD      = mrd_q;
    assign bus.mWR      = mwr_q;
    assign bus.DataAddr = addr_q;
    assign bus.DataIn   = din_q;
    assign bus.a_rvalid = a_rvalid_q;
    assign bus.a_err    = a_err_q;
    assign bus.a_rdata  = a_rdata_q;
    assign bus.b_rvalid = b_rvalid_q;
    assign bus.b_err    = b_err_q;
    assign bus.b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: drives inputs on the falling edge and
// samples registered outputs on the falling edge, against a small memory model.
module tb_dmem_arbiter;

    logic CLK = 1'b0;
    logic Reset;

    dmem_arbiter_if bus();

    dmem_arbiter #(.DEPTH(258)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model: unwritten words return a fixed pattern, writes land on negedge
    logic [31:0] mem [0:511];
    logic [511:0] written = '0;

    function automatic logic [31:0] init_word(input logic [31:0] idx);
        return (idx == 32'd4) ? 32'hDEADBEEF : {16'hA5A5, idx[15:0]};
    endfunction

    assign bus.DataOut = written[bus.DataAddr[8:0]] ? mem[bus.DataAddr[8:0]]
                                                    : init_word(bus.DataAddr);

    always @(negedge CLK) begin
        if (bus.mWR) begin
            mem[bus.DataAddr[8:0]]     <= bus.DataIn;
            written[bus.DataAddr[8:0]] <= 1'b1;
        end
    end

    task automatic idle_inputs();
        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        idle_inputs();
        #2;
        n_checks++;
        if ({bus.a_gnt, bus.b_gnt, bus.mRD, bus.mWR, bus.a_rvalid, bus.b_rvalid, bus.a_err, bus.b_err} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_strobes got %b expected 00000000",
                     {bus.a_gnt, bus.b_gnt, bus.mRD, bus.mWR, bus.a_rvalid, bus.b_rvalid, bus.a_err, bus.b_err});
        end
        n_checks++;
        if ({bus.DataAddr, bus.DataIn, bus.a_rdata, bus.b_rdata} !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_data got %h %h %h %h expected all 0", bus.DataAddr, bus.DataIn, bus.a_rdata, bus.b_rdata);
        end
        @(negedge CLK);
        @(negedge CLK);
        // Release reset with a request already waiting
        Reset = 1'b0;
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 32'h8;
        @(negedge CLK);
        n_checks++;
        if (bus.a_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL startup_first_edge a_gnt got %b expected 0", bus.a_gnt);
        end
        @(negedge CLK);
        n_checks++;
        if (bus.a_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL startup_second_edge a_gnt got %b expected 1", bus.a_gnt);
        end
        bus.a_req = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (bus.a_rvalid !== 1'b1 || bus.a_rdata !== 32'hA5A50002) begin
            n_fail++;
            $display("FAIL startup_load got rvalid=%b rdata=%h expected 1 a5a50002", bus.a_rvalid, bus.a_rdata);
        end
        $display("test_reset: startup load word 2 rdata=%h", bus.a_rdata);
    endtask

    task automatic test_single_load();
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 32'h10;
        @(negedge CLK);
        n_checks++;
        if (bus.a_gnt !== 1'b1 || bus.b_gnt !== 1'b0 || bus.mRD !== 1'b1 || bus.mWR !== 1'b0 || bus.DataAddr !== 32'd4) begin
            n_fail++;
            $display("FAIL load_gnt_cycle got gnt=%b/%b mRD=%b mWR=%b addr=%0d expected 1/0 1 0 4",
                     bus.a_gnt, bus.b_gnt, bus.mRD, bus.mWR, bus.DataAddr);
        end
        n_checks++;
        if (bus.a_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL load_early_rvalid got %b expected 0", bus.a_rvalid);
        end
        bus.a_req = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (bus.a_rvalid !== 1'b1 || bus.a_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL load_data got rvalid=%b rdata=%h expected 1 deadbeef", bus.a_rvalid, bus.a_rdata);
        end
        n_checks++;
        if (bus.a_gnt !== 1'b0 || bus.mRD !== 1'b0 || bus.DataAddr !== 32'd4) begin
            n_fail++;
            $display("FAIL load_after got gnt=%b mRD=%b addr=%0d expected 0 0 4", bus.a_gnt, bus.mRD, bus.DataAddr);
        end
        @(negedge CLK);
        n_checks++;
        if (bus.a_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL load_rvalid_width got %b expected 0", bus.a_rvalid);
        end
        $display("test_single_load: addr 0x10 rdata=%h", bus.a_rdata);
    endtask

    task automatic test_contention();
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 32'h10;
        bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 32'h200; bus.b_wdata = 32'h1;
        @(negedge CLK);
        n_checks++;
        if (bus.a_gnt !== 1'b1 || bus.b_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL contention_first got a_gnt=%b b_gnt=%b expected 1 0", bus.a_gnt, bus.b_gnt);
        end
        bus.a_req = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (bus.b_gnt !== 1'b1 || bus.a_gnt !== 1'b0 || bus.mWR !== 1'b1 || bus.mRD !== 1'b0 ||
            bus.DataAddr !== 32'd128 || bus.DataIn !== 32'h1) begin
            n_fail++;
            $display("FAIL contention_store got b_gnt=%b a_gnt=%b mWR=%b mRD=%b addr=%0d din=%h expected 1 0 1 0 128 1",
                     bus.b_gnt, bus.a_gnt, bus.mWR, bus.mRD, bus.DataAddr, bus.DataIn);
        end
        n_checks++;
        if (bus.a_rvalid !== 1'b1 || bus.a_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL contention_overlap_rvalid got %b %h expected 1 deadbeef", bus.a_rvalid, bus.a_rdata);
        end
        bus.b_req = 1'b0; bus.b_we = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (bus.b_rvalid !== 1'b0 || bus.b_err !== 1'b0 || bus.mWR !== 1'b0) begin
            n_fail++;
            $display("FAIL store_no_response got rvalid=%b err=%b mWR=%b expected 0 0 0", bus.b_rvalid, bus.b_err, bus.mWR);
        end
        // Read the stored word back through port B
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 32'h200;
        @(negedge CLK);
        n_checks++;
        if (bus.b_gnt !== 1'b1 || bus.mRD !== 1'b1) begin
            n_fail++;
            $display("FAIL readback_gnt got b_gnt=%b mRD=%b expected 1 1", bus.b_gnt, bus.mRD);
        end
        bus.b_req = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (bus.b_rvalid !== 1'b1 || bus.b_rdata !== 32'h1) begin
            n_fail++;
            $display("FAIL readback_data got rvalid=%b rdata=%h expected 1 00000001", bus.b_rvalid, bus.b_rdata);
        end
        $display("test_contention: store B word 128 readback=%h", bus.b_rdata);
    endtask

    task automatic test_fairness();
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 32'h10;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 32'h200;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            n_checks++;
            if (bus.a_gnt !== ((i % 2) == 0) || bus.b_gnt !== ((i % 2) == 1)) begin
                n_fail++;
                $display("FAIL fairness_cycle%0d got a_gnt=%b b_gnt=%b expected %b %b",
                         i, bus.a_gnt, bus.b_gnt, (i % 2) == 0, (i % 2) == 1);
            end
            $display("test_fairness: cycle %0d a_gnt=%b b_gnt=%b", i, bus.a_gnt, bus.b_gnt);
        end
        idle_inputs();
        @(negedge CLK);
        n_checks++;
        if (bus.b_rvalid !== 1'b1 || bus.b_rdata !== 32'h1 || bus.a_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL fairness_tail got b_rvalid=%b b_rdata=%h a_gnt=%b expected 1 00000001 0",
                     bus.b_rvalid, bus.b_rdata, bus.a_gnt);
        end
        @(negedge CLK);
    endtask

    task automatic test_illegal();
        logic [31:0] addrs [3];
        logic        wes   [3];
        logic [31:0] words [3];
        addrs = '{32'h6, 32'h408, 32'h402};
        wes   = '{1'b0, 1'b0, 1'b1};
        words = '{32'd1, 32'd258, 32'd256};
        for (int i = 0; i < 3; i++) begin
            bus.a_req = 1'b1; bus.a_we = wes[i]; bus.a_addr = addrs[i]; bus.a_wdata = 32'h5555AAAA;
            @(negedge CLK);
            n_checks++;
            if (bus.a_gnt !== 1'b1 || bus.mRD !== 1'b0 || bus.mWR !== 1'b0 || bus.DataAddr !== words[i]) begin
                n_fail++;
                $display("FAIL illegal_gnt_%h got gnt=%b mRD=%b mWR=%b addr=%0d expected 1 0 0 %0d",
                         addrs[i], bus.a_gnt, bus.mRD, bus.mWR, bus.DataAddr, words[i]);
            end
            bus.a_req = 1'b0; bus.a_we = 1'b0;
            @(negedge CLK);
            n_checks++;
            if (bus.a_err !== 1'b1 || bus.a_rvalid !== 1'b0 || bus.a_rdata !== 32'hDEADBEEF) begin
                n_fail++;
                $display("FAIL illegal_resp_%h got err=%b rvalid=%b rdata=%h expected 1 0 deadbeef",
                         addrs[i], bus.a_err, bus.a_rvalid, bus.a_rdata);
            end
            $display("test_illegal: addr %h we=%b err=%b", addrs[i], wes[i], bus.a_err);
            @(negedge CLK);
            n_checks++;
            if (bus.a_err !== 1'b0) begin
                n_fail++;
                $display("FAIL illegal_err_width_%h got %b expected 0", addrs[i], bus.a_err);
            end
        end
    endtask

    task automatic test_boundary();
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 32'h404;
        @(negedge CLK);
        n_checks++;
        if (bus.a_gnt !== 1'b1 || bus.mRD !== 1'b1 || bus.DataAddr !== 32'd257) begin
            n_fail++;
            $display("FAIL boundary_gnt got gnt=%b mRD=%b addr=%0d expected 1 1 257", bus.a_gnt, bus.mRD, bus.DataAddr);
        end
        bus.a_req = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (bus.a_rvalid !== 1'b1 || bus.a_err !== 1'b0 || bus.a_rdata !== 32'hA5A50101) begin
            n_fail++;
            $display("FAIL boundary_data got rvalid=%b err=%b rdata=%h expected 1 0 a5a50101",
                     bus.a_rvalid, bus.a_err, bus.a_rdata);
        end
        $display("test_boundary: word 257 rdata=%h", bus.a_rdata);
        @(negedge CLK);
    endtask

    task automatic test_reset_abort();
        logic seen;
        int   waited;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 32'h20;
        @(negedge CLK);
        n_checks++;
        if (bus.b_gnt !== 1'b1 || bus.mRD !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pre got b_gnt=%b mRD=%b expected 1 1", bus.b_gnt, bus.mRD);
        end
        #1 Reset = 1'b1;
        #1;
        n_checks++;
        if (bus.mRD !== 1'b0 || bus.b_gnt !== 1'b0 || bus.DataAddr !== 32'd0 || bus.b_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL abort_async got mRD=%b b_gnt=%b addr=%0d b_rdata=%h expected 0 0 0 0",
                     bus.mRD, bus.b_gnt, bus.DataAddr, bus.b_rdata);
        end
        @(negedge CLK);
        Reset = 1'b0;
        bus.b_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (bus.b_rvalid !== 1'b0 || bus.b_err !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_response got response=%b expected 0", seen);
        end
        // Next request on B is served normally
        bus.b_req = 1'b1;
        waited = 0;
        do begin
            @(negedge CLK);
            waited++;
        end while (bus.b_gnt !== 1'b1 && waited < 6);
        n_checks++;
        if (bus.b_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_regrant got b_gnt=%b after %0d cycles expected 1", bus.b_gnt, waited);
        end
        bus.b_req = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (bus.b_rvalid !== 1'b1 || bus.b_rdata !== 32'hA5A50008) begin
            n_fail++;
            $display("FAIL abort_reload got rvalid=%b rdata=%h expected 1 a5a50008", bus.b_rvalid, bus.b_rdata);
        end
        $display("test_reset_abort: reload word 8 rdata=%h", bus.b_rdata);
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_contention();
        test_fairness();
        test_illegal();
        test_boundary();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish within 100000 time units");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DEPTH, default 258, SHALL set the data memory size in 32-bit words; valid word indices are 0..DEPTH-1.
REQ-002 CLK  input  1  SHALL be the only clock; all state updates on posedge CLK.
REQ-003 Reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 a_req, a_we  input  1 each  SHALL carry the CPU-port request and write-enable (1=store, 0=load).
REQ-005 a_addr, a_wdata  input  32 each  SHALL carry the CPU-port byte address and store data.
REQ-006 a_gnt, a_rvalid, a_err  output  1 each  SHALL carry the CPU-port grant, load-data-valid and error pulses.
REQ-007 a_rdata  output  32  SHALL carry CPU-port load data.
REQ-008 b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_err, b_rdata SHALL be the loader/debug port, identical in width and meaning to the a_* signals.
REQ-009 mRD, mWR  output  1 each  SHALL drive the data memory read and write enables.
REQ-010 DataAddr  output  32  SHALL drive the memory word index; DataIn  output  32  SHALL drive memory write data.
REQ-011 DataOut  input  32  SHALL receive the memory's combinational read data.

Function
REQ-012 All outputs SHALL be registered; no combinational input-to-output path.
REQ-013 FSM states SHALL be IDLE, GRANT_A, GRANT_B; each GRANT state SHALL last exactly one cycle.
REQ-014 In IDLE: a_req=1 -> GRANT_A (a_req wins when both are high); else b_req=1 -> GRANT_B; else stay in IDLE.
REQ-015 In GRANT_A, a_req SHALL be masked: b_req=1 -> GRANT_B, else -> IDLE; GRANT_B is symmetric (a_req=1 -> GRANT_A, else IDLE).
REQ-016 Each port SHALL therefore get at most one grant per 2 cycles; alternating A/B traffic SHALL get one grant per cycle.
REQ-017 x_gnt SHALL be 1 exactly during GRANT_x; the requester SHALL hold req/we/addr/wdata stable from req assertion through the gnt cycle.
REQ-018 On entering GRANT_x: DataAddr = x_addr[31:2] zero-extended, DataIn = x_wdata, mRD = ~x_we, mWR = x_we, all held for that cycle only.
REQ-019 An access SHALL be illegal if x_addr[1:0] != 0 or x_addr[31:2] >= DEPTH; an illegal grant SHALL hold mRD=mWR=0, with DataAddr and DataIn still loaded.
REQ-020 Outside GRANT states mRD=mWR=0; DataAddr and DataIn SHALL hold their last values.
REQ-021 For a legal load, at the posedge ending GRANT_x, x_rdata SHALL capture DataOut and x_rvalid SHALL pulse for 1 cycle; load latency is gnt+1.
REQ-022 For an illegal access (load or store), x_err SHALL pulse for 1 cycle in the cycle after gnt, x_rvalid SHALL stay 0, and x_rdata SHALL hold its value.
REQ-023 Legal stores SHALL produce no rvalid or err; the write completes at the memory's negedge inside the gnt cycle.
REQ-024 x_rdata SHALL hold its value until the next legal load on that port.
REQ-025 Port-A and port-B rvalid/err pulses MAY occur in the same cycle as the other port's gnt.

Reset
REQ-026 Reset=1 SHALL immediately force: state IDLE; a_gnt, b_gnt, mRD, mWR, a_rvalid, b_rvalid, a_err, b_err = 0; DataAddr, DataIn, a_rdata, b_rdata = 0.
REQ-027 Reset asserted during a GRANT state SHALL abort the access: strobes drop asynchronously, and no rvalid or err follows.
REQ-028 After Reset deasserts, the first grant SHALL occur no earlier than the second posedge.

Verification
REQ-029 Single load: DataOut model returns 0xDEADBEEF, a_req=1, a_we=0, a_addr=0x10 -> a_gnt cycle shows mRD=1, DataAddr=4; next cycle a_rvalid=1, a_rdata=0xDEADBEEF.
REQ-030 Contention: a_req and b_req both raised in IDLE (store B to 0x200 data 0x1) -> GRANT_A then GRANT_B on consecutive cycles; in the B cycle mWR=1, DataAddr=128, DataIn=1.
REQ-031 Fairness: a_req and b_req held high for 6 cycles -> grants alternate A,B,A,B,...; no port is granted twice consecutively.
REQ-032 Illegal access: a_addr=0x6, then a_addr=0x408 (word 258) -> mRD=mWR=0 in both gnt cycles; a_err pulses after each; a_rvalid stays 0.
REQ-033 Reset mid-access: Reset pulsed during GRANT_B of a load -> mRD drops at once; b_rvalid never pulses; the next b_req is served normally.
REQ-034 Boundary: load from a_addr=0x404 (word 257) is legal -> mRD=1, DataAddr=257, a_rvalid pulses.
